// File: rtl/data_memory_unit_pkg.sv
// Shared constants for the data memory unit: default geometry, byte-lane
// width and the bit positions of the response flags stored next to the data.
package data_memory_unit_pkg;

  localparam int DMU_DEFAULT_DATA_WIDTH = 32;
  localparam int DMU_DEFAULT_DEPTH      = 1024;
  localparam int DMU_LANE_WIDTH         = 8;

  // A response word is {is_write, error, data}; the flag positions are
  // given as offsets above the data field.
  localparam int DMU_FLAG_ERROR_OFS     = 0;
  localparam int DMU_FLAG_IS_WRITE_OFS  = 1;

  // Index width for a storage of n entries, never narrower than one bit.
  function automatic int dmu_index_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/data_memory_unit_response_fifo.sv
// Synchronous response FIFO holding {is_write, error, data} words.
// Head is presented combinationally from the read pointer.
module data_memory_unit_response_fifo
  import data_memory_unit_pkg::*;
#(
  parameter int WIDTH = DMU_DEFAULT_DATA_WIDTH + 2,
  parameter int DEPTH = 4
) (
  input  logic             system_clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = dmu_index_width(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] slots [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & ~full;
  assign head    = slots[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge system_clock) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // Storage write; contents need no reset since occupancy gates visibility.
  always_ff @(posedge system_clock) begin
    if (do_push) slots[wr_ptr] <= push_data;
  end

  // The upstream credit counter must never let a push reach a full FIFO.
  assert property (@(posedge system_clock) disable iff (reset) !(push && full));

endmodule

// File: rtl/data_memory_unit.sv
// Pipelined data memory for the MEM stage. Valid/ready request port,
// in-order responses after READ_LATENCY cycles, byte-lane writes,
// out-of-range detection and a credit-limited response FIFO.
// Optional feature macro: DMU_ALIGN_CHECK_EN (misaligned requests error out).
module data_memory_unit
  import data_memory_unit_pkg::*;
#(
  parameter int DATA_WIDTH   = DMU_DEFAULT_DATA_WIDTH,
  parameter int DEPTH        = DMU_DEFAULT_DEPTH,
  parameter int ADDR_WIDTH   = 32,
  parameter int READ_LATENCY = 2,
  parameter int RESP_DEPTH   = 4,
  localparam int BE_WIDTH    = DATA_WIDTH / DMU_LANE_WIDTH
) (
  input  logic                  system_clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_address,
  input  logic [DATA_WIDTH-1:0] req_write_data,
  input  logic [BE_WIDTH-1:0]   req_byte_enable,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_read_data,
  output logic                  resp_is_write,
  output logic                  resp_error
);

  localparam int LANE_BITS = (BE_WIDTH > 1) ? $clog2(BE_WIDTH) : 0;
  localparam int IDX_W     = dmu_index_width(DEPTH);
  localparam int CNT_W     = $clog2(RESP_DEPTH + 1);
  localparam int RESP_W    = DATA_WIDTH + 2;
  localparam int ERR_BIT   = DATA_WIDTH + DMU_FLAG_ERROR_OFS;
  localparam int WR_BIT    = DATA_WIDTH + DMU_FLAG_IS_WRITE_OFS;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] word_index;
  logic [IDX_W-1:0]      mem_index;
  logic                  req_error;
  logic                  accept;
  logic                  pop;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [CNT_W-1:0]      outstanding;

  logic [READ_LATENCY-1:0] pipe_valid;
  logic [RESP_W-1:0]       pipe_word [READ_LATENCY];

  logic              fifo_full;
  logic              fifo_empty;
  logic [RESP_W-1:0] fifo_head;

  assign word_index = req_address >> LANE_BITS;
  assign mem_index  = word_index[IDX_W-1:0];

`ifdef DMU_ALIGN_CHECK_EN
  assign req_error = (word_index >= ADDR_WIDTH'(DEPTH)) ||
                     ((req_address & ADDR_WIDTH'(BE_WIDTH - 1)) != '0);
`else
  assign req_error = (word_index >= ADDR_WIDTH'(DEPTH));
`endif

  assign req_ready = !reset && (outstanding < CNT_W'(RESP_DEPTH));
  assign accept    = req_valid & req_ready;
  assign pop       = resp_valid & resp_ready;
  assign rd_data   = (req_write || req_error) ? '0 : mem[mem_index];

  // Byte-lane store committed at the accept edge; rejected requests never write.
  always_ff @(posedge system_clock) begin
    if (accept && req_write && !req_error) begin
      for (int i = 0; i < BE_WIDTH; i++) begin
        if (req_byte_enable[i])
          mem[mem_index][i*DMU_LANE_WIDTH +: DMU_LANE_WIDTH] <=
            req_write_data[i*DMU_LANE_WIDTH +: DMU_LANE_WIDTH];
      end
    end
  end

  // Valid bits of the read pipeline; stage 0 is loaded at the accept edge.
  always_ff @(posedge system_clock) begin
    if (reset) begin
      pipe_valid <= '0;
    end else begin
      pipe_valid[0] <= accept;
      for (int k = 1; k < READ_LATENCY; k++) pipe_valid[k] <= pipe_valid[k-1];
    end
  end

  // Response words follow their valid bits; payload needs no reset.
  always_ff @(posedge system_clock) begin
    pipe_word[0] <= {req_write, req_error, rd_data};
    for (int k = 1; k < READ_LATENCY; k++) pipe_word[k] <= pipe_word[k-1];
  end

  // Credits: requests accepted but not yet handed to the consumer.
  always_ff @(posedge system_clock) begin
    if (reset) begin
      outstanding <= '0;
    end else if (accept && !pop) begin
      outstanding <= outstanding + 1'b1;
    end else if (pop && !accept) begin
      outstanding <= outstanding - 1'b1;
    end
  end

  data_memory_unit_response_fifo #(
    .WIDTH (RESP_W),
    .DEPTH (RESP_DEPTH)
  ) u_response_fifo (
    .system_clock (system_clock),
    .reset        (reset),
    .push         (pipe_valid[READ_LATENCY-1]),
    .push_data    (pipe_word[READ_LATENCY-1]),
    .pop          (pop),
    .full         (fifo_full),
    .empty        (fifo_empty),
    .head         (fifo_head)
  );

  // Outputs read as zero whenever no response is present.
  always_comb begin
    resp_valid     = !fifo_empty;
    resp_read_data = '0;
    resp_is_write  = 1'b0;
    resp_error     = 1'b0;
    if (!fifo_empty) begin
      resp_read_data = fifo_head[DATA_WIDTH-1:0];
      resp_is_write  = fifo_head[WR_BIT];
      resp_error     = fifo_head[ERR_BIT];
    end
  end

endmodule

// File: tb/tb_data_memory_unit.sv
// Directed self-checking bench for data_memory_unit (default parameters).
module tb_data_memory_unit;

  logic        system_clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_address = '0;
  logic [31:0] req_write_data = '0;
  logic [3:0]  req_byte_enable = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_read_data;
  logic        resp_is_write;
  logic        resp_error;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  data_memory_unit dut (
    .system_clock    (system_clock),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_address     (req_address),
    .req_write_data  (req_write_data),
    .req_byte_enable (req_byte_enable),
    .resp_valid      (resp_valid),
    .resp_ready      (resp_ready),
    .resp_read_data  (resp_read_data),
    .resp_is_write   (resp_is_write),
    .resp_error      (resp_error)
  );

  always #5 system_clock = ~system_clock;
  always @(posedge system_clock) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog expired tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  // Present one request and hold it until accepted; acc = edge number of accept.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, output int acc);
    bit rdy;
    acc = -1;
    req_valid = 1'b1; req_write = w; req_address = a;
    req_write_data = d; req_byte_enable = be;
    for (int i = 0; i < 30; i++) begin
      rdy = req_ready;
      @(posedge system_clock); #1;
      if (rdy) begin acc = cyc; break; end
    end
    req_valid = 1'b0;
    if (acc < 0) begin
      tests++; fails++;
      $display("FAIL issue_timeout addr %h not accepted, required acceptance", a);
    end
  endtask

  // Wait for a response (resp_ready must be 1) and consume it; rc = edge it became visible.
  task automatic get_resp(output logic [31:0] d, output logic w, output logic e, output int rc);
    rc = -1; d = '0; w = 1'b0; e = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (resp_valid) begin
        d = resp_read_data; w = resp_is_write; e = resp_error; rc = cyc;
        @(posedge system_clock); #1;
        break;
      end
      @(posedge system_clock); #1;
    end
    if (rc < 0) begin
      tests++; fails++;
      $display("FAIL resp_timeout no response seen, required one");
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge system_clock);
    #1;
    tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL rst_req_ready got %b want 0", req_ready); end
    tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL rst_resp_valid got %b want 0", resp_valid); end
    tests++; if ({resp_read_data, resp_is_write, resp_error} !== 34'h0) begin
      fails++; $display("FAIL rst_resp_fields got %h/%b/%b want 0", resp_read_data, resp_is_write, resp_error);
    end
    reset = 1'b0; #1;
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL rst_release_ready got %b want 1", req_ready); end
    @(posedge system_clock); #1;
  endtask

  task automatic test_write_read();
    int a, r; logic [31:0] d; logic w, e;
    resp_ready = 1'b1;
    issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, a);
    get_resp(d, w, e, r);
    tests++; if (w !== 1'b1 || e !== 1'b0 || d !== 32'h0) begin
      fails++; $display("FAIL t1_write_resp got w%b e%b d%h want w1 e0 d0", w, e, d);
    end
    issue(1'b0, 32'h10, 32'h0, 4'h0, a);
    get_resp(d, w, e, r);
    tests++; if (d !== 32'hDEADBEEF || e !== 1'b0 || w !== 1'b0) begin
      fails++; $display("FAIL t1_read_resp got d%h e%b w%b want dDEADBEEF e0 w0", d, e, w);
    end
    tests++; if (r - a != 2) begin fails++; $display("FAIL t1_latency got %0d want 2", r - a); end
  endtask

  task automatic test_byte_lanes();
    int a, r; logic [31:0] d; logic w, e;
    issue(1'b1, 32'h20, 32'h11223344, 4'hF, a); get_resp(d, w, e, r);
    issue(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, a); get_resp(d, w, e, r);
    issue(1'b0, 32'h20, 32'h0, 4'h0, a); get_resp(d, w, e, r);
    tests++; if (d !== 32'h11BB33DD) begin fails++; $display("FAIL t2_lane_merge got %h want 11BB33DD", d); end
    issue(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, a); get_resp(d, w, e, r);
    tests++; if (w !== 1'b1 || e !== 1'b0) begin fails++; $display("FAIL t2_be0_resp got w%b e%b want w1 e0", w, e); end
    issue(1'b0, 32'h20, 32'h0, 4'h0, a); get_resp(d, w, e, r);
    tests++; if (d !== 32'h11BB33DD) begin fails++; $display("FAIL t2_be0_nowrite got %h want 11BB33DD", d); end
  endtask

  task automatic test_backpressure();
    logic [31:0] addrs [4];
    logic [31:0] exp [4];
    int a, r, n; bit rdy; logic [31:0] d; logic w, e;
    addrs = '{32'h10, 32'h20, 32'h30, 32'h40};
    exp   = '{32'hDEADBEEF, 32'h11BB33DD, 32'h30303030, 32'h40404040};
    issue(1'b1, 32'h30, 32'h30303030, 4'hF, a); get_resp(d, w, e, r);
    issue(1'b1, 32'h40, 32'h40404040, 4'hF, a); get_resp(d, w, e, r);
    resp_ready = 1'b0;
    n = 0;
    req_valid = 1'b1; req_write = 1'b0; req_address = addrs[0];
    for (int i = 0; i < 10; i++) begin
      rdy = req_ready;
      @(posedge system_clock); #1;
      if (rdy) begin n++; if (n < 4) req_address = addrs[n]; end
    end
    req_valid = 1'b0;
    tests++; if (n != 4) begin fails++; $display("FAIL t3_accept_count got %0d want 4", n); end
    tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL t3_ready_full got %b want 0", req_ready); end
    resp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tests++; if (resp_valid !== 1'b1 || resp_read_data !== exp[k]) begin
        fails++; $display("FAIL t3_drain_%0d got v%b d%h want v1 d%h", k, resp_valid, resp_read_data, exp[k]);
      end
      @(posedge system_clock); #1;
      if (k == 0) begin
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL t3_ready_return got %b want 1", req_ready); end
      end
    end
    tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL t3_drained got %b want 0", resp_valid); end
  endtask

  task automatic test_out_of_range();
    int a, r; logic [31:0] d; logic w, e;
    issue(1'b1, 32'h0, 32'h0000A5A5, 4'hF, a); get_resp(d, w, e, r);
    issue(1'b0, 32'h1000, 32'h0, 4'h0, a); get_resp(d, w, e, r);
    tests++; if (e !== 1'b1 || d !== 32'h0) begin fails++; $display("FAIL t4_oor_read got e%b d%h want e1 d0", e, d); end
    issue(1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, a); get_resp(d, w, e, r);
    tests++; if (e !== 1'b1 || w !== 1'b1) begin fails++; $display("FAIL t4_oor_write got e%b w%b want e1 w1", e, w); end
    issue(1'b0, 32'h0, 32'h0, 4'h0, a); get_resp(d, w, e, r);
    tests++; if (d !== 32'h0000A5A5 || e !== 1'b0) begin
      fails++; $display("FAIL t4_index0_kept got d%h e%b want d0000A5A5 e0", d, e);
    end
  endtask

  task automatic test_reset_midflight();
    int a, r, n, seen; bit rdy; logic [31:0] d; logic w, e;
    issue(1'b1, 32'h50, 32'h5A5A5A5A, 4'hF, a); get_resp(d, w, e, r);
    resp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_address = 32'h50;
    repeat (3) begin @(posedge system_clock); #1; end
    req_valid = 1'b0;
    reset = 1'b1; #1;
    tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL t5_ready_in_reset got %b want 0", req_ready); end
    @(posedge system_clock); #1;
    reset = 1'b0; #1;
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL t5_ready_after got %b want 1", req_ready); end
    seen = 0;
    resp_ready = 1'b1;
    repeat (6) begin @(posedge system_clock); #1; if (resp_valid) seen++; end
    tests++; if (seen != 0) begin fails++; $display("FAIL t5_dropped got %0d responses want 0", seen); end
    resp_ready = 1'b0; n = 0;
    req_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rdy = req_ready;
      @(posedge system_clock); #1;
      if (rdy) n++;
    end
    req_valid = 1'b0;
    tests++; if (n != 4) begin fails++; $display("FAIL t5_credits got %0d accepts want 4", n); end
    resp_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      get_resp(d, w, e, r);
      if (d === 32'h5A5A5A5A) seen++;
    end
    tests++; if (seen != 4) begin fails++; $display("FAIL t5_persist got %0d good reads want 4", seen); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [4];
    logic [31:0] exp [4];
    int rdy_ok, rsp_ok;
    addrs = '{32'h40, 32'h30, 32'h20, 32'h10};
    exp   = '{32'h40404040, 32'h30303030, 32'h11BB33DD, 32'hDEADBEEF};
    resp_ready = 1'b1; rdy_ok = 0; rsp_ok = 0;
    for (int s = 0; s < 8; s++) begin
      if (s >= 3 && s <= 6 && resp_valid === 1'b1 && resp_read_data === exp[s-3]) rsp_ok++;
      if (s < 4) begin
        req_valid = 1'b1; req_write = 1'b0; req_address = addrs[s];
        if (req_ready === 1'b1) rdy_ok++;
      end else begin
        req_valid = 1'b0;
      end
      @(posedge system_clock); #1;
    end
    tests++; if (rdy_ok != 4) begin fails++; $display("FAIL b2b_ready got %0d want 4", rdy_ok); end
    tests++; if (rsp_ok != 4) begin fails++; $display("FAIL b2b_responses got %0d in-slot want 4", rsp_ok); end
  endtask

  task automatic test_misaligned();
    int a, r; logic [31:0] d; logic w, e;
    issue(1'b0, 32'h13, 32'h0, 4'h0, a); get_resp(d, w, e, r);
`ifdef DMU_ALIGN_CHECK_EN
    tests++; if (e !== 1'b1 || d !== 32'h0) begin fails++; $display("FAIL t6_misaligned got e%b d%h want e1 d0", e, d); end
`else
    tests++; if (e !== 1'b0 || d !== 32'hDEADBEEF) begin
      fails++; $display("FAIL t6_unaligned got e%b d%h want e0 dDEADBEEF", e, d);
    end
`endif
    tests++; if (r - a != 2) begin fails++; $display("FAIL t6_latency got %0d want 2", r - a); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_backpressure();
    test_out_of_range();
    test_reset_midflight();
    test_back_to_back();
    test_misaligned();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
